// File: rtl/uart_cmd_ctrl.sv
// ============================================================================
// uart_cmd_ctrl
// ----------------------------------------------------------------------------
// Single-letter ASCII command interpreter sitting between a UART RX FIFO, a
// UART TX FIFO and a free-running 16-bit counter.  One command byte is taken
// from the RX FIFO at a time, decoded, acted upon, and answered on the TX FIFO.
//
//   R/r : start counter (run_en <= 1)            answer 'K'
//   S/s : stop counter  (run_en <= 0)            answer 'K'
//   C/c : one-cycle clear_pulse                  answer 'K'
//   D/d : toggle count direction (dir_down)      answer 'K'
//   Q/q : report count_value as 4 hex digits + CR LF
//   any other byte                               answer '?'
//
// Optional feature (compile-time macro):
//   UART_CMD_ECHO_EN - when defined, every received byte is echoed to the TX
//                      FIFO before its response.  When undefined the ECHO
//                      state does not exist.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   rx_fifo_empty   RX FIFO empty (first-word-fall-through)
//   rx_fifo_rdata   RX FIFO head byte
//   rx_fifo_pop     consume RX head byte this cycle
//   tx_fifo_full    TX FIFO full
//   tx_fifo_push    write tx_fifo_wdata this cycle
//   tx_fifo_wdata   byte to write (0x00 when not pushing)
//   count_value     live counter value
//   run_en          counter enable level
//   clear_pulse     one-cycle counter clear
//   dir_down        counter direction, 1 = down
//   busy            high whenever a command is being processed
// ============================================================================
module uart_cmd_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_fifo_empty,
    input  logic [7:0]  rx_fifo_rdata,
    output logic        rx_fifo_pop,
    input  logic        tx_fifo_full,
    output logic        tx_fifo_push,
    output logic [7:0]  tx_fifo_wdata,
    input  logic [15:0] count_value,
    output logic        run_en,
    output logic        clear_pulse,
    output logic        dir_down,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
`ifdef UART_CMD_ECHO_EN
    localparam logic [1:0] ECHO   = 2'd1;
`endif
    localparam logic [1:0] DECODE = 2'd2;
    localparam logic [1:0] SEND   = 2'd3;

    logic [1:0] state;
    logic [7:0] cmd_reg;
    logic [15:0] rpt_reg;
    logic [2:0] byte_idx;
    logic [7:0] resp_byte;
    logic       query_resp;

    logic [7:0] cmd_upper;
    logic [7:0] send_byte;
    logic       last_byte;
    logic       can_push;

    function automatic logic [7:0] hex_digit(input logic [3:0] n);
        // 0x37 + n maps 10..15 onto 'A'..'F'
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // Clearing bit 5 folds lower-case letters onto upper case; no other byte
    // can alias onto one of the five command letters this way.
    assign cmd_upper = cmd_reg & 8'hDF;

    assign busy = (state != IDLE);

    // Pop and push are combinational so they land in the same cycle as the
    // state that owns them; reset masks both so nothing moves in a reset cycle.
    assign rx_fifo_pop = !rst && (state == IDLE) && !rx_fifo_empty;

`ifdef UART_CMD_ECHO_EN
    assign can_push = !rst && !tx_fifo_full && ((state == SEND) || (state == ECHO));
`else
    assign can_push = !rst && !tx_fifo_full && (state == SEND);
`endif

    assign tx_fifo_push = can_push;

    // Report bytes are generated from the snapshot register, so the live
    // counter moving during SEND cannot disturb them.
    always_comb begin
        send_byte = resp_byte;
        if (query_resp) begin
            case (byte_idx)
                3'd0:    send_byte = hex_digit(rpt_reg[15:12]);
                3'd1:    send_byte = hex_digit(rpt_reg[11:8]);
                3'd2:    send_byte = hex_digit(rpt_reg[7:4]);
                3'd3:    send_byte = hex_digit(rpt_reg[3:0]);
                3'd4:    send_byte = 8'h0D;
                default: send_byte = 8'h0A;
            endcase
        end
    end

    assign last_byte = query_resp ? (byte_idx == 3'd5) : 1'b1;

    // Data bus is forced to zero whenever nothing is being written.
    always_comb begin
        tx_fifo_wdata = 8'h00;
        if (can_push) begin
`ifdef UART_CMD_ECHO_EN
            tx_fifo_wdata = (state == ECHO) ? cmd_reg : send_byte;
`else
            tx_fifo_wdata = send_byte;
`endif
        end
    end

    // Main sequencer: fetch one byte, optionally echo it, decode and act on
    // it, then stream the response out under TX backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_reg     <= 8'h00;
            rpt_reg     <= 16'h0000;
            byte_idx    <= 3'd0;
            resp_byte   <= 8'h00;
            query_resp  <= 1'b0;
            run_en      <= 1'b0;
            dir_down    <= 1'b0;
            clear_pulse <= 1'b0;
        end else begin
            clear_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_fifo_empty) begin
                        cmd_reg <= rx_fifo_rdata;
`ifdef UART_CMD_ECHO_EN
                        state   <= ECHO;
`else
                        state   <= DECODE;
`endif
                    end
                end
`ifdef UART_CMD_ECHO_EN
                ECHO: begin
                    if (can_push) begin
                        state <= DECODE;
                    end
                end
`endif
                DECODE: begin
                    byte_idx   <= 3'd0;
                    query_resp <= 1'b0;
                    resp_byte  <= 8'h4B;
                    state      <= SEND;
                    case (cmd_upper)
                        8'h52: run_en      <= 1'b1;
                        8'h53: run_en      <= 1'b0;
                        8'h43: clear_pulse <= 1'b1;
                        8'h44: dir_down    <= ~dir_down;
                        8'h51: begin
                            rpt_reg    <= count_value;
                            query_resp <= 1'b1;
                        end
                        default: resp_byte <= 8'h3F;
                    endcase
                end
                SEND: begin
                    if (can_push) begin
                        if (last_byte) begin
                            byte_idx <= 3'd0;
                            state    <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
